hack_ram_arbiter: RTL
=====================

Name: hack_ram_arbiter

Overview:
- Two-port arbiter sharing the single-port 16K x 16 Hack data RAM (SPRAM, 1-cycle read latency) between requesters.
- Port A is the Hack CPU data bus and has priority. Port B is a secondary master (program loader or screen fetch).
- Port B has a bounded-wait guarantee.
- Sits between the requesters and the RAM wrapper; drives the RAM's in/load/address and consumes its out.

Parameters:
- ADDR_W, 14, RAM word-address width.
- DATA_W, 16, data width.
- MAX_WAIT, 4, consecutive cycles B may be denied before it is forced to win one contended cycle (1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  A access request, this cycle.
- a_we  input  1  A write (1) / read (0).
- a_addr  input  ADDR_W  A word address.
- a_wdata  input  DATA_W  A write data.
- a_gnt  output  1  A access accepted this cycle (combinational).
- a_rvalid  output  1  A read data valid (registered).
- a_rdata  output  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for port B.
- ram_addr  output  ADDR_W  to RAM address.
- ram_wdata  output  DATA_W  to RAM in.
- ram_wren  output  1  to RAM load.
- ram_rdata  input  DATA_W  from RAM out, valid the cycle after a read is issued.

Behaviour:
- Reset: rst_n low immediately clears a_rvalid, b_rvalid, wait counter and the read-return tag. Outputs while in reset: ram_wren=0, a_gnt=0, b_gnt=0, a_rdata=b_rdata=0.
- Grant (combinational, same cycle):
  - Only a_req: a_gnt=1.
  - Only b_req: b_gnt=1.
  - Both: b_gnt=1 if wait_cnt==MAX_WAIT, else a_gnt=1.
  - Never both grants in one cycle.
- A request is accepted when req && gnt. The requester must hold req/we/addr/wdata stable until granted.
- RAM drive:
  - ram_addr/ram_wdata come from the granted port.
  - ram_wren = granted we.
  - With no grant: ram_addr=a_addr, ram_wdata=a_wdata, ram_wren=0.
- Read latency:
  - A granted read in cycle N gives rvalid=1 for exactly one cycle in N+1 on the owning port only.
  - rdata = ram_rdata in that cycle.
  - Tag register records the owner. Writes produce no rvalid.
  - Back-to-back reads are fully pipelined: 1 access per cycle.
- rdata when rvalid=0: holds last returned value for that port (no glitch to 0 after reset).
- Wait counter (4 bits):
  - Increments each cycle b_req && !b_gnt, saturating at MAX_WAIT.
  - Clears on any b_gnt.
  - Clears when b_req=0.
- Read-during-write: a read and a write never share a cycle. A read issued the cycle after a write to the same address returns the new data.
- Reset mid-operation: an in-flight read return is dropped (no rvalid after reset deasserts). The first cycle after release arbitrates from wait_cnt=0.
- Address/data widths pass straight through; no arithmetic, no address decode.

Test Plan:
- Reset: hold rst_n=0 with a_req=1, a_we=1 -> ram_wren=0, both gnt=0, both rvalid=0. Release -> a_gnt=1 the same cycle.
- A only: write 0x1234 to addr 0x0010, then read 0x0010 next cycle -> ram_wren=1 in cycle 1; a_rvalid=1 with a_rdata=0x1234 in cycle 3; b_rvalid stays 0.
- B only, pipelined: B reads addr 0..3 on consecutive cycles (RAM preloaded with 0xB000+addr) -> b_rvalid high 4 consecutive cycles, data 0xB000..0xB003 in order.
- Contention starvation, MAX_WAIT=4: a_req and b_req held for 10 cycles -> grant sequence A,A,A,A,B,A,A,A,A,B. wait_cnt peaks at 4, clears after each B grant.
- Mixed tag: A read 0x0005 (=0x00AA) in cycle N, B read 0x0006 (=0x00BB) in N+1 -> a_rvalid/0x00AA at N+1, b_rvalid/0x00BB at N+2; never both rvalids in one cycle.
- Reset mid-read: B read granted in cycle N, rst_n low asynchronously in N+1 before the edge -> b_rvalid never asserts. wait_cnt=0 after release.

Source files
------------

// File: rtl/hack_ram_arbiter.sv
// ---------------------------------------------------------------------------
// hack_ram_arbiter
//
// Shares the single-port Hack data RAM (16K x 16, one-cycle registered read)
// between two masters. Port A (the CPU data bus) has priority. Port B (loader
// or screen fetch) wins one contended cycle after it has been refused
// MAX_WAIT times in a row, so its wait is bounded.
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request; held stable until a_gnt
//   a_gnt                      port A accepted this cycle (combinational)
//   a_rvalid/a_rdata           port A read return, one cycle after grant
//   b_*                        same set of signals for port B
//   ram_addr/ram_wdata/ram_wren  drive to the RAM wrapper
//   ram_rdata                  RAM output, valid the cycle after a read
//
// MAX_WAIT must lie in 1..15 so that it fits the 4-bit wait counter.
// ---------------------------------------------------------------------------
module hack_ram_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt_reg;
  logic              rd_valid_reg;  // a read was issued last cycle
  logic              rd_tag_reg;    // owner of that read: 0 = A, 1 = B
  logic [DATA_W-1:0] a_hold_reg;
  logic [DATA_W-1:0] b_hold_reg;

  logic a_win;
  logic b_win;
  logic rd_issue;

  // Grants are forced low while reset is asserted so nothing reaches the RAM.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (rst_n) begin
      if (a_req && b_req) begin
        if (wait_cnt_reg == MAX_WAIT_C) begin
          b_win = 1'b1;
        end else begin
          a_win = 1'b1;
        end
      end else if (a_req) begin
        a_win = 1'b1;
      end else if (b_req) begin
        b_win = 1'b1;
      end
    end
  end

  assign a_gnt = a_win;
  assign b_gnt = b_win;

  // With no grant the RAM still sees port A's address/data, but never a write.
  assign ram_addr  = b_win ? b_addr  : a_addr;
  assign ram_wdata = b_win ? b_wdata : a_wdata;
  assign ram_wren  = (a_win && a_we) || (b_win && b_we);

  assign rd_issue = (a_win && !a_we) || (b_win && !b_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= 4'd0;
      rd_valid_reg <= 1'b0;
      rd_tag_reg   <= 1'b0;
      a_hold_reg   <= '0;
      b_hold_reg   <= '0;
    end else begin
      rd_valid_reg <= rd_issue;
      if (rd_issue) begin
        rd_tag_reg <= b_win;
      end

      // Counts refused B cycles; any B grant or a dropped request restarts it.
      if (b_req && !b_win) begin
        if (wait_cnt_reg != MAX_WAIT_C) begin
          wait_cnt_reg <= wait_cnt_reg + 4'd1;
        end
      end else begin
        wait_cnt_reg <= 4'd0;
      end

      // Capture the returned word so rdata holds it after rvalid drops.
      if (a_rvalid) begin
        a_hold_reg <= ram_rdata;
      end
      if (b_rvalid) begin
        b_hold_reg <= ram_rdata;
      end
    end
  end

  assign a_rvalid = rd_valid_reg && !rd_tag_reg;
  assign b_rvalid = rd_valid_reg &&  rd_tag_reg;

  // Return data comes straight from the RAM in the valid cycle, then holds.
  assign a_rdata = a_rvalid ? ram_rdata : a_hold_reg;
  assign b_rdata = b_rvalid ? ram_rdata : b_hold_reg;

endmodule
